// File: rtl/obstacle_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dino_pkg
// Description : Shared game-level definitions: scheduler state encoding,
//               obstacle type codes, obstacle geometry, screen/track
//               constants and the LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

    // Screen and track geometry, shared by obstacle, dino and collision blocks
    localparam int c_screen_width  = 640;
    localparam int c_screen_height = 480;
    localparam int c_ground_y      = 400;
    localparam int c_air_y         = 340;

    // Obstacle geometry in pixels
    localparam int c_cactus_width  = 20;
    localparam int c_cactus_height = 40;
    localparam int c_pter_width    = 40;
    localparam int c_pter_height   = 24;

    // Game / scheduler state encoding, visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } sched_state_e;

    // Obstacle type codes carried by spawn_type
    typedef enum logic [1:0] {
        OBS_CACTUS      = 2'd0,
        OBS_PTER_AIR    = 2'd1,
        OBS_PTER_GROUND = 2'd2
    } obs_type_e;

    // One step of the 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    // A nonzero state never maps to zero, so the sequence cannot lock up.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        logic fb;
        fb = cur[7] ^ cur[5] ^ cur[4] ^ cur[3];
        return {cur[6:0], fb};
    endfunction

    // Reduce a random byte to an obstacle type code (0..2)
    function automatic logic [1:0] pick_type(input logic [7:0] rnd);
        logic [7:0] rem;
        rem = rnd % 8'd3;
        return rem[1:0];
    endfunction

endpackage : dino_pkg
`default_nettype wire

// File: rtl/obstacle_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_scheduler_if
// Description : Bundle between the game FSM / obstacle slots (master) and the
//               obstacle scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface obstacle_scheduler_if;

    logic        start;          // start/restart pulse
    logic        frame_tick;     // one pulse per game frame
    logic        collision;      // dino hit an obstacle
    logic [1:0]  slot_active;    // bit i high while slot i is on screen
    logic [9:0]  slot0_h;        // slot 0 right-edge x
    logic [9:0]  slot1_h;        // slot 1 right-edge x
    logic [1:0]  spawn;          // one-hot spawn command per slot
    logic [1:0]  spawn_type;     // obstacle type, valid with spawn
    logic [5:0]  obstacle_hvel;  // common horizontal velocity
    logic [15:0] score;          // frames survived
    logic [1:0]  state;          // IDLE / RUN / DEAD

    modport master (
        output start, frame_tick, collision, slot_active, slot0_h, slot1_h,
        input  spawn, spawn_type, obstacle_hvel, score, state
    );

    modport slave (
        input  start, frame_tick, collision, slot_active, slot0_h, slot1_h,
        output spawn, spawn_type, obstacle_hvel, score, state
    );

endinterface : obstacle_scheduler_if
`default_nettype wire

// File: rtl/obstacle_scheduler_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : Free-running 8-bit Fibonacci LFSR with a parameterised,
//               nonzero reset seed. Advances every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import dino_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr_q;
    logic [7:0] w_lfsr_d;

    // Next pseudo-random value
    always_comb begin
        w_lfsr_d = lfsr8_next(r_lfsr_q);
    end

    // Shift register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr_q <= SEED;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign o_lfsr = r_lfsr_q;

endmodule : lfsr8
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_scheduler
// Description : Sequences two obstacle slots on the shared track: decides
//               spawn timing and type, enforces the spawn gap, ramps the
//               common velocity and freezes the track on collision.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int         SCREEN_WIDTH = c_screen_width,
    parameter int         MIN_GAP      = 200,
    parameter int         MIN_DELAY    = 20,
    parameter int         BASE_VEL     = 5,
    parameter int         MAX_VEL      = 12,
    parameter int         RAMP_TICKS   = 600,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    obstacle_scheduler_if.slave  bus
);

    // Delay counter must hold MIN_DELAY plus a 6-bit random extension
    localparam int c_delay_w = $clog2(MIN_DELAY + 64);
    localparam int c_ramp_w  = $clog2(RAMP_TICKS + 1);

    localparam logic [9:0]           c_gap_limit = 10'(SCREEN_WIDTH - MIN_GAP);
    localparam logic [5:0]           c_base_vel  = 6'(BASE_VEL);
    localparam logic [5:0]           c_max_vel   = 6'(MAX_VEL);
    localparam logic [c_delay_w-1:0] c_min_delay = c_delay_w'(MIN_DELAY);
    localparam logic [c_ramp_w-1:0]  c_ramp_last = c_ramp_w'(RAMP_TICKS - 1);

    logic [7:0]           w_lfsr;

    sched_state_e         r_state_q,      w_state_d;
    logic [1:0]           r_spawn_q,      w_spawn_d;
    logic [1:0]           r_spawn_type_q, w_spawn_type_d;
    logic [5:0]           r_hvel_q,       w_hvel_d;
    logic [15:0]          r_score_q,      w_score_d;
    logic [c_delay_w-1:0] r_delay_q,      w_delay_d;
    logic [c_ramp_w-1:0]  r_ramp_q,       w_ramp_d;
    logic                 r_last_slot_q,  w_last_slot_d;

    logic                 w_slot_free;
    logic                 w_target;
    logic [9:0]           w_last_h;
    logic                 w_gap_ok;

    lfsr8 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_lfsr (w_lfsr)
    );

    // Spawn eligibility: a free slot exists and the last spawned obstacle has
    // either left the screen or travelled far enough from the right edge
    always_comb begin
        w_slot_free = (bus.slot_active != 2'b11);
        w_target    = bus.slot_active[0];
        w_last_h    = r_last_slot_q ? bus.slot1_h : bus.slot0_h;
        w_gap_ok    = !bus.slot_active[r_last_slot_q] || (w_last_h <= c_gap_limit);
    end

    // Next-state and datapath updates for the IDLE/RUN/DEAD controller
    always_comb begin
        w_state_d      = r_state_q;
        w_spawn_d      = 2'b00;
        w_spawn_type_d = r_spawn_type_q;
        w_hvel_d       = r_hvel_q;
        w_score_d      = r_score_q;
        w_delay_d      = r_delay_q;
        w_ramp_d       = r_ramp_q;
        w_last_slot_d  = r_last_slot_q;

        case (r_state_q)
            ST_IDLE: begin
                w_hvel_d = c_base_vel;
                if (bus.start) begin
                    w_state_d = ST_RUN;
                    w_score_d = 16'd0;
                    w_ramp_d  = '0;
                    w_delay_d = c_min_delay;
                end
            end

            ST_RUN: begin
                // Collision wins over both frame updates and spawn decisions
                if (bus.collision) begin
                    w_state_d = ST_DEAD;
                    w_hvel_d  = 6'd0;
                end else if (bus.frame_tick) begin
                    if (r_score_q != 16'hFFFF) begin
                        w_score_d = r_score_q + 16'd1;
                    end

                    if (r_ramp_q == c_ramp_last) begin
                        w_ramp_d = '0;
                        if (r_hvel_q < c_max_vel) begin
                            w_hvel_d = r_hvel_q + 6'd1;
                        end
                    end else begin
                        w_ramp_d = r_ramp_q + 1'b1;
                    end

                    if (r_delay_q != '0) begin
                        w_delay_d = r_delay_q - 1'b1;
                    end else if (w_slot_free && w_gap_ok) begin
                        w_spawn_d      = w_target ? 2'b10 : 2'b01;
                        w_spawn_type_d = pick_type(w_lfsr);
                        w_last_slot_d  = w_target;
                        w_delay_d      = c_min_delay + c_delay_w'(w_lfsr[5:0]);
                    end
                end
            end

            ST_DEAD: begin
                w_hvel_d = 6'd0;
                if (bus.start) begin
                    w_state_d = ST_RUN;
                    w_hvel_d  = c_base_vel;
                    w_score_d = 16'd0;
                    w_ramp_d  = '0;
                    w_delay_d = c_min_delay;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_hvel_d  = c_base_vel;
            end
        endcase
    end

    // Controller registers; reset also drops any spawn pulse about to issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_spawn_q      <= 2'b00;
            r_spawn_type_q <= 2'd0;
            r_hvel_q       <= c_base_vel;
            r_score_q      <= 16'd0;
            r_delay_q      <= '0;
            r_ramp_q       <= '0;
            r_last_slot_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_spawn_q      <= w_spawn_d;
            r_spawn_type_q <= w_spawn_type_d;
            r_hvel_q       <= w_hvel_d;
            r_score_q      <= w_score_d;
            r_delay_q      <= w_delay_d;
            r_ramp_q       <= w_ramp_d;
            r_last_slot_q  <= w_last_slot_d;
        end
    end

    assign bus.spawn         = r_spawn_q;
    assign bus.spawn_type    = r_spawn_type_q;
    assign bus.obstacle_hvel = r_hvel_q;
    assign bus.score         = r_score_q;
    assign bus.state         = r_state_q;

endmodule : obstacle_scheduler
`default_nettype wire
